// File: rtl/mem_arbiter_pkg.sv
// Shared types for the LC-3b physical memory arbiter.
package mem_arbiter_pkg;

   typedef logic [127:0] lc3b_line;

   typedef enum logic [1:0] {
      arb_idle,
      arb_serve_i,
      arb_serve_d,
      arb_release
   } lc3b_arb_state;

   typedef enum logic {
      grant_i,
      grant_d
   } lc3b_arb_grant;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single pmem port between icache and dcache; a grant lasts a whole
// line transaction and ties alternate between the two caches.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned LINE_WIDTH = $bits(lc3b_line),
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic [LINE_WIDTH-1:0] i_rdata,
   output logic                  i_resp,

   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  d_resp,

   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   lc3b_arb_state state, state_next;
   lc3b_arb_grant last_grant, last_grant_next;
   logic          d_pend;

   assign d_pend = d_read | d_write;

   // State and fairness history; reset leaves D as the winner of the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= arb_idle;
         last_grant <= grant_i;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
      end
   end

   // Next-state: arbitrate only in IDLE; RELEASE lets the finished cache drop its request.
   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      case (state)
         arb_idle: begin
            if (d_pend && i_read) begin
               state_next = (last_grant == grant_i) ? arb_serve_d : arb_serve_i;
            end else if (d_pend) begin
               state_next = arb_serve_d;
            end else if (i_read) begin
               state_next = arb_serve_i;
            end
         end
         arb_serve_i: begin
            if (pmem_resp) begin
               state_next      = arb_release;
               last_grant_next = grant_i;
            end
         end
         arb_serve_d: begin
            if (pmem_resp) begin
               state_next      = arb_release;
               last_grant_next = grant_d;
            end
         end
         arb_release: state_next = arb_idle;
         default:     state_next = arb_idle;
      endcase
   end

   // Output routing; reset forces everything low so an aborted strobe drops at once.
   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      i_rdata      = '0;
      i_resp       = 1'b0;
      d_rdata      = '0;
      d_resp       = 1'b0;
      if (!reset) begin
         case (state)
            arb_serve_i: begin
               pmem_read    = 1'b1;
               pmem_address = i_address;
               i_rdata      = pmem_rdata;
               i_resp       = pmem_resp;
            end
            arb_serve_d: begin
               pmem_write   = d_write;
               pmem_read    = d_read & ~d_write;
               pmem_address = d_address;
               pmem_wdata   = d_wdata;
               d_rdata      = pmem_rdata;
               d_resp       = pmem_resp;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected pmem transactions are queued when
// requests are driven and popped when the arbiter raises a strobe.
module tb_mem_arbiter;

   localparam int unsigned LW = 128;
   localparam int unsigned AW = 16;
   localparam int WAIT_MAX = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_read;
   logic [AW-1:0] i_address;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_address;
   logic [LW-1:0] d_wdata;
   logic [LW-1:0] d_rdata;
   logic          d_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata;
   logic          pmem_resp;

   always #5 clk = ~clk;

   mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_read       (i_read),
      .i_address    (i_address),
      .i_rdata      (i_rdata),
      .i_resp       (i_resp),
      .d_read       (d_read),
      .d_write      (d_write),
      .d_address    (d_address),
      .d_wdata      (d_wdata),
      .d_rdata      (d_rdata),
      .d_resp       (d_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   typedef struct {
      bit            is_d;
      bit            wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
   } txn_t;

   txn_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic txn_t mk(bit is_d, bit wr, logic [AW-1:0] addr, logic [LW-1:0] wdata);
      txn_t t;
      t.is_d  = is_d;
      t.wr    = wr;
      t.addr  = addr;
      t.wdata = wdata;
      return t;
   endfunction

   task automatic clear_inputs();
      i_read     = 1'b0;
      i_address  = '0;
      d_read     = 1'b0;
      d_write    = 1'b0;
      d_address  = '0;
      d_wdata    = '0;
      pmem_rdata = '0;
      pmem_resp  = 1'b0;
   endtask

   // Returns the number of negedges waited until a strobe is seen (WAIT_MAX on timeout).
   task automatic wait_strobe(output int waited);
      waited = 0;
      while (!(pmem_read || pmem_write) && waited < WAIT_MAX) begin
         @(negedge clk); #1;
         waited++;
      end
   endtask

   task automatic test_reset();
      bit bad = 0;
      reset = 1'b1;
      clear_inputs();
      i_read     = 1'b1;
      d_write    = 1'b1;
      d_wdata    = '1;
      pmem_rdata = '1;
      pmem_resp  = 1'b1;
      repeat (3) begin
         @(negedge clk); #1;
         if ({pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp, d_resp, i_rdata, d_rdata} !== '0)
            bad = 1;
      end
      n_cmp++;
      if (bad) begin
         n_bad++;
         $display("FAIL reset_outputs: outputs nonzero during reset (pr=%b pw=%b ir=%b dr=%b) required all 0",
                  pmem_read, pmem_write, i_resp, d_resp);
      end
      @(negedge clk);
      clear_inputs();
      reset = 1'b0;
      @(negedge clk); #1;
      n_cmp++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_idle: strobes/resp=%b required 0000", {pmem_read, pmem_write, i_resp, d_resp});
      end
   endtask

   task automatic test_single_i();
      txn_t          e;
      logic [LW-1:0] rd = {16{8'hA5}};
      @(negedge clk);
      i_read    = 1'b1;
      i_address = 16'h0040;
      exp_q.push_back(mk(1'b0, 1'b0, 16'h0040, '0));
      #1;
      n_cmp++;
      if (pmem_read !== 1'b0) begin
         n_bad++;
         $display("FAIL single_i_latency: pmem_read=%b required 0 in request cycle", pmem_read);
      end
      @(negedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({pmem_read, pmem_write, pmem_address, pmem_wdata} !== {~e.wr, e.wr, e.addr, e.wdata}) begin
         n_bad++;
         $display("FAIL single_i_strobe: r=%b w=%b addr=%h required r=1 w=0 addr=%h",
                  pmem_read, pmem_write, pmem_address, e.addr);
      end
      pmem_rdata = rd;
      pmem_resp  = 1'b1;
      #1;
      n_cmp++;
      if ({i_resp, d_resp, i_rdata, d_rdata} !== {1'b1, 1'b0, rd, LW'(0)}) begin
         n_bad++;
         $display("FAIL single_i_resp: i_resp=%b d_resp=%b i_rdata=%h required 1 0 %h",
                  i_resp, d_resp, i_rdata, rd);
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      i_read    = 1'b0;
      #1;
      n_cmp++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
         n_bad++;
         $display("FAIL single_i_release: strobes/resp=%b required 0000", {pmem_read, pmem_write, i_resp, d_resp});
      end
      @(negedge clk); #1;
   endtask

   task automatic test_dwrite();
      txn_t          e;
      int            w;
      logic [LW-1:0] wd = {8{16'h1234}};
      logic [LW-1:0] rd = {4{32'h5A5A_0F0F}};
      @(negedge clk);
      d_write   = 1'b1;
      d_address = 16'h1230;
      d_wdata   = wd;
      exp_q.push_back(mk(1'b1, 1'b1, 16'h1230, wd));
      #1;
      wait_strobe(w);
      n_cmp++;
      if (w >= WAIT_MAX) begin
         n_bad++;
         $display("FAIL dwrite_timeout: waited=%0d required <%0d", w, WAIT_MAX);
         return;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if ({pmem_read, pmem_write, pmem_address, pmem_wdata} !== {~e.wr, e.wr, e.addr, e.wdata}) begin
         n_bad++;
         $display("FAIL dwrite_strobe: r=%b w=%b addr=%h wdata=%h required r=0 w=1 addr=%h wdata=%h",
                  pmem_read, pmem_write, pmem_address, pmem_wdata, e.addr, e.wdata);
      end
      pmem_rdata = rd;
      pmem_resp  = 1'b1;
      #1;
      n_cmp++;
      if ({i_resp, d_resp, i_rdata, d_rdata} !== {1'b0, 1'b1, LW'(0), rd}) begin
         n_bad++;
         $display("FAIL dwrite_resp: i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h required 0 1 0 %h",
                  i_resp, d_resp, i_rdata, d_rdata, rd);
      end
      // pmem_resp left high through RELEASE and IDLE must not be forwarded
      @(negedge clk);
      d_write = 1'b0;
      #1;
      n_cmp++;
      if ({pmem_read, pmem_write, i_resp, d_resp, d_rdata} !== {4'b0000, LW'(0)}) begin
         n_bad++;
         $display("FAIL dwrite_release: strobes/resp=%b d_rdata=%h required 0000 and 0",
                  {pmem_read, pmem_write, i_resp, d_resp}, d_rdata);
      end
      @(negedge clk); #1;
      n_cmp++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
         n_bad++;
         $display("FAIL idle_resp_ignored: strobes/resp=%b required 0000", {pmem_read, pmem_write, i_resp, d_resp});
      end
      pmem_resp = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic test_fairness();
      txn_t          e;
      int            w;
      logic [LW-1:0] dwd = {4{32'hDDDD_0000}};
      logic [LW-1:0] rd;
      bit            bad = 0;
      reset = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      reset     = 1'b0;
      i_read    = 1'b1;
      i_address = 16'h0100;
      d_read    = 1'b1;
      d_address = 16'h0200;
      d_wdata   = dwd;
      for (int k = 0; k < 6; k++)
         exp_q.push_back((k % 2 == 0) ? mk(1'b1, 1'b0, 16'h0200, dwd) : mk(1'b0, 1'b0, 16'h0100, '0));
      #1;
      for (int k = 0; k < 6; k++) begin
         wait_strobe(w);
         n_cmp++;
         if (w >= WAIT_MAX) begin
            n_bad++;
            $display("FAIL fair_timeout: txn %0d waited=%0d", k, w);
            return;
         end
         if (k > 0) begin
            n_cmp++;
            if (w !== 2) begin
               n_bad++;
               $display("FAIL fair_spacing: txn %0d gap=%0d required 2", k, w);
            end
         end
         e = exp_q.pop_front();
         n_cmp++;
         if ({pmem_read, pmem_write, pmem_address, pmem_wdata} !== {1'b1, 1'b0, e.addr, e.wdata}) begin
            n_bad++;
            $display("FAIL fair_order: txn %0d addr=%h wdata=%h required addr=%h wdata=%h",
                     k, pmem_address, pmem_wdata, e.addr, e.wdata);
         end
         rd         = {4{32'hC0DE_0000 + 32'(k)}};
         pmem_rdata = rd;
         pmem_resp  = 1'b1;
         #1;
         n_cmp++;
         if ({i_resp, d_resp, i_rdata, d_rdata} !==
             (e.is_d ? {1'b0, 1'b1, LW'(0), rd} : {1'b1, 1'b0, rd, LW'(0)})) begin
            n_bad++;
            $display("FAIL fair_route: txn %0d i_resp=%b d_resp=%b required d_side=%b", k, i_resp, d_resp, e.is_d);
         end
         @(negedge clk);
         pmem_resp = 1'b0;
         #1;
      end
      i_read = 1'b0;
      d_read = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         if (pmem_read || pmem_write) bad = 1;
      end
      n_cmp++;
      if (bad) begin
         n_bad++;
         $display("FAIL fair_drain: strobe seen after both requests dropped");
      end
   endtask

   task automatic test_stale_release();
      txn_t e;
      int   w;
      bit   bad = 0;
      @(negedge clk);
      i_read    = 1'b1;
      i_address = 16'h0080;
      exp_q.push_back(mk(1'b0, 1'b0, 16'h0080, '0));
      #1;
      wait_strobe(w);
      n_cmp++;
      if (w >= WAIT_MAX) begin
         n_bad++;
         $display("FAIL stale_timeout: waited=%0d", w);
         return;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if ({pmem_read, pmem_address} !== {1'b1, e.addr}) begin
         n_bad++;
         $display("FAIL stale_strobe: r=%b addr=%h required 1 %h", pmem_read, pmem_address, e.addr);
      end
      pmem_rdata = '1;
      pmem_resp  = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      if (pmem_read || pmem_write) bad = 1;
      @(negedge clk);
      i_read = 1'b0;
      #1;
      if (pmem_read || pmem_write) bad = 1;
      repeat (3) begin
         @(negedge clk); #1;
         if (pmem_read || pmem_write) bad = 1;
      end
      n_cmp++;
      if (bad) begin
         n_bad++;
         $display("FAIL stale_regrant: second strobe issued for a request held only through RELEASE");
      end
   endtask

   task automatic test_illegal_rw();
      txn_t          e;
      int            w;
      logic [LW-1:0] wd = {4{32'hBEEF_CAFE}};
      @(negedge clk);
      d_read    = 1'b1;
      d_write   = 1'b1;
      d_address = 16'h3000;
      d_wdata   = wd;
      exp_q.push_back(mk(1'b1, 1'b1, 16'h3000, wd));
      #1;
      wait_strobe(w);
      n_cmp++;
      if (w >= WAIT_MAX) begin
         n_bad++;
         $display("FAIL illegal_timeout: waited=%0d", w);
         return;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if ({pmem_read, pmem_write, pmem_address, pmem_wdata} !== {~e.wr, e.wr, e.addr, e.wdata}) begin
         n_bad++;
         $display("FAIL illegal_rw: r=%b w=%b addr=%h required r=0 w=1 addr=%h", pmem_read, pmem_write, pmem_address, e.addr);
      end
      pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      d_read    = 1'b0;
      d_write   = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic test_reset_mid();
      txn_t e;
      int   w;
      @(negedge clk);
      d_write   = 1'b1;
      d_address = 16'h4440;
      d_wdata   = {2{64'h0123_4567_89AB_CDEF}};
      exp_q.push_back(mk(1'b1, 1'b1, 16'h4440, {2{64'h0123_4567_89AB_CDEF}}));
      #1;
      wait_strobe(w);
      n_cmp++;
      if (w >= WAIT_MAX) begin
         n_bad++;
         $display("FAIL rmid_timeout: waited=%0d", w);
         return;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if ({pmem_write, pmem_address} !== {1'b1, e.addr}) begin
         n_bad++;
         $display("FAIL rmid_strobe: w=%b addr=%h required 1 %h", pmem_write, pmem_address, e.addr);
      end
      reset   = 1'b1;
      d_write = 1'b0;
      #1;
      n_cmp++;
      if ({pmem_read, pmem_write} !== 2'b00) begin
         n_bad++;
         $display("FAIL rmid_drop: r=%b w=%b required 00 immediately on reset", pmem_read, pmem_write);
      end
      @(negedge clk);
      reset     = 1'b0;
      pmem_resp = 1'b1;
      #1;
      n_cmp++;
      if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
         n_bad++;
         $display("FAIL rmid_spurious: strobes/resp=%b required 0000", {pmem_read, pmem_write, i_resp, d_resp});
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      // last_grant returns to I on reset, so D must win the next tie
      i_read    = 1'b1;
      i_address = 16'h0500;
      d_read    = 1'b1;
      d_address = 16'h0600;
      d_wdata   = '0;
      exp_q.push_back(mk(1'b1, 1'b0, 16'h0600, '0));
      #1;
      wait_strobe(w);
      e = exp_q.pop_front();
      n_cmp++;
      if ({pmem_read, pmem_address} !== {1'b1, e.addr}) begin
         n_bad++;
         $display("FAIL rmid_tie: r=%b addr=%h required 1 %h", pmem_read, pmem_address, e.addr);
      end
      pmem_resp = 1'b1;
      @(negedge clk);
      pmem_resp = 1'b0;
      d_read    = 1'b0;
      i_read    = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_i();
      test_dwrite();
      test_fairness();
      test_stale_release();
      test_illegal_rw();
      test_reset_mid();
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d expected transactions left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
